// File: rtl/store_merge_unit_if.sv
// store_merge_unit_if: CPU store request and data memory port bundle for store_merge_unit.
interface store_merge_unit_if #(
    parameter int CPU_WORD = 32,
    parameter int ADDR_W   = 32
);
    logic                sw;
    logic                sh;
    logic                sb;
    logic [ADDR_W-1:0]   addr;
    logic [CPU_WORD-1:0] wdata;
    logic                ready;
    logic                done;
    logic                err;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_re;
    logic [CPU_WORD-1:0] mem_rdata;
    logic                mem_we;
    logic [CPU_WORD-1:0] mem_wdata;

    modport master (
        output sw, sh, sb, addr, wdata, mem_rdata,
        input  ready, done, err, mem_addr, mem_re, mem_we, mem_wdata
    );
    modport slave (
        input  sw, sh, sb, addr, wdata, mem_rdata,
        output ready, done, err, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/store_merge_unit.sv
// store_merge_unit: word/half/byte stores into word memory, read-modify-write for sub-words.
// Define STORE_MISALIGN_TRAP_EN to trap misaligned sh/sw through a one-cycle ERR state.
module store_merge_unit #(
    parameter int CPU_WORD = 32,
    parameter int ADDR_W   = 32,
    parameter int HALF_LEN = 16,
    parameter int BYTE_LEN = 8
) (
    input logic              clk,
    input logic              rst_n,
    store_merge_unit_if.slave bus
);
`ifdef STORE_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE} state_t;
`endif
    typedef enum logic [1:0] {ST_W, ST_H, ST_B} kind_t;

    state_t              st, nxt, go;
    kind_t               kind;
    logic                req;
    logic [ADDR_W-1:0]   addr_q;
    logic [HALF_LEN-1:0] data_q;
    logic [CPU_WORD-1:0] mrg_q, merged;

    assign req = bus.sw | bus.sh | bus.sb;
    assign go  = (bus.sh || bus.sb) ? READ : WRITE;

`ifdef STORE_MISALIGN_TRAP_EN
    logic mis;
    assign mis = bus.sh ? bus.addr[0] : (!bus.sb && bus.addr[1:0] != 2'b00);
`endif

    always_comb begin
        nxt = st;
        unique case (st)
`ifdef STORE_MISALIGN_TRAP_EN
            IDLE:    nxt = !req ? IDLE : mis ? ERR : go;
`else
            IDLE:    nxt = !req ? IDLE : go;
`endif
            READ:    nxt = MERGE;
            MERGE:   nxt = WRITE;
            default: nxt = IDLE;
        endcase
    end

    // Replace one lane of the word just read; the other lanes pass through.
    always_comb begin
        merged = bus.mem_rdata;
        if (kind == ST_B)
            merged[int'(addr_q[1:0]) * BYTE_LEN +: BYTE_LEN] = data_q[BYTE_LEN-1:0];
        else
            merged[int'(addr_q[1]) * HALF_LEN +: HALF_LEN] = data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= IDLE;
            kind   <= ST_W;
            addr_q <= '0;
            data_q <= '0;
            mrg_q  <= '0;
        end else begin
            st <= nxt;
            if (st == IDLE && req) begin
                addr_q <= bus.addr;
                data_q <= bus.wdata[HALF_LEN-1:0];
                kind   <= bus.sh ? ST_H : bus.sb ? ST_B : ST_W;
                if (!bus.sh && !bus.sb) mrg_q <= bus.wdata;
            end
            if (st == MERGE) mrg_q <= merged;
        end
    end

    assign bus.ready     = (st == IDLE);
    assign bus.mem_re    = (st == READ);
    assign bus.mem_we    = (st == WRITE);
    assign bus.done      = (st == WRITE);
    assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = mrg_q;
`ifdef STORE_MISALIGN_TRAP_EN
    assign bus.err       = (st == ERR);
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed + random stores checked against a byte-level memory model.
module tb_store_merge_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    store_merge_unit_if #(.CPU_WORD(32), .ADDR_W(32)) bus ();

    store_merge_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Memory with one-cycle read latency and full-word writes.
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic setw(input logic [31:0] a, input logic [31:0] v);
        mem[a[9:2]]     = v;
        ref_mem[a[9:2]] = v;
    endtask

    task automatic clr();
        bus.sw = 1'b0;
        bus.sh = 1'b0;
        bus.sb = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle.
    task automatic store(input logic s_w, input logic s_h, input logic s_b,
                         input logic [31:0] a, input logic [31:0] d, input bit junk);
        logic        is_w, is_b, mis;
        logic [7:0]  by [4];
        logic [31:0] exp_w;
        logic [4:0]  st, ex;
        int          n;
        is_b = !s_h && s_b;
        is_w = !s_h && !s_b && s_w;
        mis  = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
        mis = (s_h && a[0]) || (is_w && a[1:0] != 2'b00);
`endif
        exp_w = ref_mem[a[9:2]];
        for (int i = 0; i < 4; i++) by[i] = exp_w[8*i +: 8];
        if (is_b) by[a[1:0]] = d[7:0];
        else if (s_h) begin
            by[{a[1], 1'b0}] = d[7:0];
            by[{a[1], 1'b1}] = d[15:8];
        end
        exp_w = is_w ? d : {by[3], by[2], by[1], by[0]};
        n = (mis || is_w) ? 2 : 4;
        bus.sw = s_w; bus.sh = s_h; bus.sb = s_b;
        bus.addr = a; bus.wdata = d;
        chk("ready_c0", {31'b0, bus.ready}, 32'd1);
        @(posedge clk);
        #1;
        if (junk) begin
            bus.sw = 1'b1; bus.addr = a + 32'd4; bus.wdata = ~d;
        end else clr();
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            ex = {c == n, !mis && !is_w && c == 1, !mis && c == n - 1,
                  !mis && c == n - 1, mis && c == 1};
            st = {bus.ready, bus.mem_re, bus.mem_we, bus.done, bus.err};
            chk($sformatf("ctl_c%0d a=%h", c, a), {27'b0, st}, {27'b0, ex});
            if (c == n - 1 || c == 1) chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
            if (!mis && c == n - 1) chk($sformatf("wdata a=%h", a), bus.mem_wdata, exp_w);
            if (c == 1) clr();
        end
        if (!mis) ref_mem[a[9:2]] = exp_w;
    endtask

    initial begin
        logic [2:0] v;
        clr();
        bus.addr = '0;
        bus.wdata = '0;
        for (int i = 0; i < 256; i++) setw(32'(i) << 2, $urandom);
        #3;
        chk("rst_ctl", {27'b0, bus.ready, bus.mem_re, bus.mem_we, bus.done, bus.err}, 32'h10);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        #10 rst_n = 1'b1;
        @(negedge clk);

        setw(32'h100, 32'hAABBCCDD);
        store(0, 0, 1, 32'h102, 32'h00000011, 0);
        store(0, 1, 0, 32'h102, 32'hFFFF1234, 0);
        store(1, 0, 0, 32'h104, 32'hDEADBEEF, 1);
        store(1, 0, 0, 32'h108, 32'h01234567, 0);
        setw(32'h100, 32'hAABBCCDD);
        store(1, 1, 1, 32'h100, 32'h00005678, 0);
        setw(32'h100, 32'hAABBCCDD);
        store(0, 1, 0, 32'h101, 32'h00001234, 0);
        store(1, 0, 0, 32'h10E, 32'hCAFEF00D, 0);

        // Reset during MERGE must abort the store with no write.
        setw(32'h100, 32'hAABBCCDD);
        bus.sb = 1'b1; bus.addr = 32'h100; bus.wdata = 32'h77;
        @(posedge clk);
        #1 clr();
        @(negedge clk);
        chk("abort_c1", {27'b0, bus.ready, bus.mem_re, bus.mem_we, bus.done, bus.err}, 32'h08);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rst_ctl", {27'b0, bus.ready, bus.mem_re, bus.mem_we, bus.done, bus.err}, 32'h10);
        chk("abort_rst_addr", bus.mem_addr, 32'h0);
        chk("abort_rst_wdata", bus.mem_wdata, 32'h0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_idle", {27'b0, bus.ready, bus.mem_re, bus.mem_we, bus.done, bus.err}, 32'h10);
        end
        chk("abort_mem", mem[32'h100 >> 2], 32'hAABBCCDD);

        for (int i = 0; i < 60; i++) begin
            v = 3'($urandom_range(1, 7));
            store(v[0], v[1], v[2], 32'h100 + 32'($urandom_range(0, 255)), $urandom, 0);
        end

        @(negedge clk);
        for (int i = 'h40; i < 'h80; i++) chk($sformatf("mem[%0h]", i), mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
